// File: rtl/cic_decim_controller_pkg.sv
// Shared state codes and default parameters for the CIC decimation controller.
package cic_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_RUN    = 2'd2;

  localparam int DATA_W_DEF   = 24;
  localparam int RATIO_W_DEF  = 8;
  localparam int SETTLE_N_DEF = 3;
  localparam int MIN_RATIO    = 2;

endpackage

// File: rtl/cic_decim_controller_if.sv
// Captured-sample stream between the controller and its consumer.
interface cic_decim_controller_if import cic_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/cic_decim_controller_phase.sv
// Active-ratio register, decimation phase counter and strobe generation.
module decim_phase_counter import cic_ctrl_pkg::*; #(
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_load,
  input  logic               clr,
  input  logic               cnt_en,
  input  logic               stb_en,
  output logic               dec_stb
);

  logic [RATIO_W-1:0] ratio;
  logic [RATIO_W-1:0] phase;
  logic [RATIO_W-1:0] last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio <= RATIO_W'(MIN_RATIO);
    end else if (cfg_load) begin
      ratio <= (cfg_ratio < RATIO_W'(MIN_RATIO)) ? RATIO_W'(MIN_RATIO) : cfg_ratio;
    end
  end

  assign last = ratio - RATIO_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (cnt_en) begin
      phase <= (phase == last) ? '0 : phase + RATIO_W'(1);
    end
  end

  assign dec_stb = stb_en & (phase == last);

endmodule

// File: rtl/cic_decim_controller.sv
// Sequences the CIC comb strobe, discards settling outputs and captures samples.
//   state  | meaning
//   IDLE   | disabled, phase held at 0, last sample still consumable
//   SETTLE | strobing, discarding the first SETTLE_N filter outputs
//   RUN    | strobing and capturing each filter output
module cic_decim_controller import cic_ctrl_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RATIO_W  = RATIO_W_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [RATIO_W-1:0]            cfg_ratio,
  input  logic                          cfg_load,
  input  logic [DATA_W-1:0]             cic_out,
  output logic                          dec_stb,
  cic_decim_controller_if.master        stream,
  output logic                          overrun,
  input  logic                          clr_ovr,
  output state_t                        state
);

  localparam int CNT_W = (SETTLE_N < 1) ? 1 : $clog2(SETTLE_N + 1);

  logic [CNT_W-1:0] settle_cnt;
  logic             pending;
  logic             active;
  logic             restart;
  logic             cap;
  logic             ovr_set;

  assign active  = (state != ST_IDLE);
  assign restart = cfg_load & active;

  decim_phase_counter #(.RATIO_W(RATIO_W)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .cfg_ratio (cfg_ratio),
    .cfg_load  (cfg_load),
    .clr       (~en | restart | ~active),
    .cnt_en    (active),
    .stb_en    (active & en),
    .dec_stb   (dec_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      pending    <= 1'b0;
    end else if (!en) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      pending    <= 1'b0;
    end else if (restart) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      pending    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          pending    <= 1'b0;
        end
        ST_SETTLE: begin
          pending <= 1'b0;
          if (dec_stb) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
            if (settle_cnt + CNT_W'(1) == CNT_W'(SETTLE_N)) state <= ST_RUN;
          end
        end
        ST_RUN:  pending <= dec_stb;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The filter output for a RUN strobe is valid one cycle later; a restart or disable drops it.
  assign cap     = pending & en & ~cfg_load;
  assign ovr_set = cap & stream.out_valid & ~stream.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (cap) begin
        stream.out_data  <= cic_out;
        stream.out_valid <= 1'b1;
      end else if (stream.out_valid && stream.out_ready) begin
        stream.out_valid <= 1'b0;
      end
      overrun <= ovr_set | (overrun & ~clr_ovr);
    end
  end

endmodule

// File: tb/tb_cic_decim_controller.sv
// Bench for cic_decim_controller: cycle model compared every cycle plus directed literal checks.
module tb_cic_decim_controller;
  import cic_ctrl_pkg::*;

  localparam int DW = 24;
  localparam int RW = 8;
  localparam int SN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_load = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [RW-1:0] cfg_ratio = '0;
  logic [DW-1:0] cic_out = '0;
  logic          dec_stb;
  logic          overrun;
  state_t        state;

  cic_decim_controller_if #(.DATA_W(DW)) sif ();

  cic_decim_controller #(.DATA_W(DW), .RATIO_W(RW), .SETTLE_N(SN)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_ratio (cfg_ratio),
    .cfg_load  (cfg_load),
    .cic_out   (cic_out),
    .dec_stb   (dec_stb),
    .stream    (sif),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .state     (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since (re)start, strobe count since (re)start, ratio; strobes when (t+1) is a multiple of R.
  bit            m_active = 1'b0;
  int            m_t = 0;
  int            m_r = 2;
  int            m_nstb = 0;
  bit            m_pend = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit            m_valid = 1'b0;
  bit            m_ovr = 1'b0;
  bit            m_stb, m_cap, m_oset;
  int            m_nr;
  int            exp_state;

  always begin
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_t = 0; m_r = 2; m_nstb = 0; m_pend = 1'b0;
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      m_stb  = m_active && en && ((m_t + 1) % m_r == 0);
      m_cap  = m_pend && en && !cfg_load;
      m_oset = m_cap && m_valid && !sif.out_ready;
      if (m_cap) begin
        m_data  = cic_out;
        m_valid = 1'b1;
      end else if (m_valid && sif.out_ready) begin
        m_valid = 1'b0;
      end
      m_ovr = m_oset || (m_ovr && !clr_ovr);
      m_nr  = cfg_load ? ((int'(cfg_ratio) < 2) ? 2 : int'(cfg_ratio)) : m_r;
      if (!en) begin
        m_active = 1'b0; m_t = 0; m_nstb = 0; m_pend = 1'b0;
      end else if (!m_active || cfg_load) begin
        m_active = 1'b1; m_t = 0; m_nstb = 0; m_pend = 1'b0;
      end else begin
        m_pend = m_stb && (m_nstb >= SN);
        if (m_stb) m_nstb++;
        m_t++;
      end
      m_r = m_nr;
    end
    #1;
    exp_state = !m_active ? 0 : ((m_nstb < SN) ? 1 : 2);
    chk("model_state", 32'(state), 32'(exp_state));
    chk("model_dec_stb", 32'(dec_stb), 32'(m_active && en && ((m_t + 1) % m_r == 0)));
    chk("model_out_valid", 32'(sif.out_valid), 32'(m_valid));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
    chk("model_out_data", 32'(sif.out_data), 32'(m_data));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cic_out = cic_out + 24'h010101;
    end
  endtask

  initial begin
    sif.out_ready = 1'b0;
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dec_stb", 32'(dec_stb), 32'd0);
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_out_data", 32'(sif.out_data), 32'd0);

    // R=4, then enable: strobes 4, 8, 12 cycles after en is driven
    rst = 1'b0; cfg_ratio = 8'd4; cfg_load = 1'b1;
    tick(1); cfg_load = 1'b0; en = 1'b1;
    tick(3); chk("r4_no_stb_c3", 32'(dec_stb), 32'd0);
    tick(1); chk("r4_stb_c4", 32'(dec_stb), 32'd1); chk("r4_settle", 32'(state), 32'd1);
    tick(4); chk("r4_stb_c8", 32'(dec_stb), 32'd1);
    tick(4); chk("r4_stb_c12", 32'(dec_stb), 32'd1); chk("r4_still_settle", 32'(state), 32'd1);
    tick(1); chk("r4_run", 32'(state), 32'd2);
    tick(3); chk("r4_stb_c16", 32'(dec_stb), 32'd1); chk("r4_no_cap_yet", 32'(sif.out_valid), 32'd0);
    tick(1); cic_out = 24'h111111;
    tick(1); chk("cap1_valid", 32'(sif.out_valid), 32'd1); chk("cap1_data", 32'(sif.out_data), 32'h111111);

    // second capture with out_ready low -> overrun
    tick(3); cic_out = 24'h222222;
    tick(1);
    chk("ovr_data", 32'(sif.out_data), 32'h222222);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(sif.out_valid), 32'd1);
    clr_ovr = 1'b1;
    tick(1); clr_ovr = 1'b0; chk("ovr_cleared", 32'(overrun), 32'd0);

    // capture coinciding with a handshake
    tick(2); cic_out = 24'h333333; sif.out_ready = 1'b1;
    tick(1);
    chk("hs_valid", 32'(sif.out_valid), 32'd1);
    chk("hs_no_ovr", 32'(overrun), 32'd0);
    chk("hs_data", 32'(sif.out_data), 32'h333333);
    tick(1); sif.out_ready = 1'b0;
    chk("hs_consumed", 32'(sif.out_valid), 32'd0);

    // reload R=8 mid-RUN
    cfg_ratio = 8'd8; cfg_load = 1'b1;
    tick(1); cfg_load = 1'b0; chk("r8_settle", 32'(state), 32'd1);
    tick(6); chk("r8_no_stb_c7", 32'(dec_stb), 32'd0);
    tick(1); chk("r8_stb_c8", 32'(dec_stb), 32'd1);
    tick(17); chk("r8_run", 32'(state), 32'd2);
    tick(8); chk("r8_no_cap_yet", 32'(sif.out_valid), 32'd0);
    tick(1); chk("r8_cap", 32'(sif.out_valid), 32'd1);

    // ratio 1 clamps to 2, then drop en mid-RUN
    cfg_ratio = 8'd1; cfg_load = 1'b1;
    tick(1); cfg_load = 1'b0;
    tick(1); chk("r1_stb_a", 32'(dec_stb), 32'd1);
    tick(1); chk("r1_gap", 32'(dec_stb), 32'd0);
    tick(1); chk("r1_stb_b", 32'(dec_stb), 32'd1);
    tick(4); en = 1'b0; #1; chk("en_drop_no_stb", 32'(dec_stb), 32'd0);
    tick(1); chk("en_drop_idle", 32'(state), 32'd0); chk("en_drop_keep_valid", 32'(sif.out_valid), 32'd1);
    tick(1); chk("idle_no_stb", 32'(dec_stb), 32'd0);

    // ratio 0 clamps to 2, then reset between capture and consume
    en = 1'b1; cfg_ratio = 8'd0; cfg_load = 1'b1; sif.out_ready = 1'b1;
    tick(1); cfg_load = 1'b0; sif.out_ready = 1'b0; chk("r0_consumed", 32'(sif.out_valid), 32'd0);
    tick(1); chk("r0_stb", 32'(dec_stb), 32'd1);
    tick(8); chk("r0_cap", 32'(sif.out_valid), 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    tick(2); rst = 1'b0;
    tick(9); chk("post_rst_no_cap", 32'(sif.out_valid), 32'd0);
    tick(1); chk("post_rst_cap", 32'(sif.out_valid), 32'd1);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decim_controller.md
CIC_DECIM_CONTROLLER -- requirements
Module: cic_decim_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 24: width of the filter output word.
REQ-002 SHALL have parameter RATIO_W, default 8: width of the decimation-ratio configuration.
REQ-003 SHALL have parameter SETTLE_N, default 3: number of post-start filter outputs to discard (the CIC order).
REQ-004 SHALL have port clk, input, 1: single clock domain; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1: run enable.
REQ-007 SHALL have port cfg_ratio, input, RATIO_W: decimation ratio R; values below 2 are treated as 2.
REQ-008 SHALL have port cfg_load, input, 1: one-cycle pulse that applies cfg_ratio.
REQ-009 SHALL have port cic_out, input, DATA_W: raw decimated output from the filter.
REQ-010 SHALL have port dec_stb, output, 1: one-cycle decimation strobe to the filter comb stage.
REQ-011 SHALL have port out_data, output, DATA_W: captured sample.
REQ-012 SHALL have port out_valid, output, 1: out_data holds an unconsumed sample.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the sample.
REQ-014 SHALL have port overrun, output, 1: sticky flag, set when an unconsumed sample is overwritten.
REQ-015 SHALL have port clr_ovr, input, 1: clears overrun.
REQ-016 SHALL have port state, output, 2: current FSM state code.

Function
REQ-017 SHALL implement a three-state FSM: IDLE=0, SETTLE=1, RUN=2.
REQ-018 SHALL transition IDLE->SETTLE on en=1, with the phase counter and settle counter both set to 0.
REQ-019 SHALL transition SETTLE->RUN on the dec_stb cycle that makes the settle count reach SETTLE_N.
REQ-020 SHALL transition from any state to IDLE when en=0, and SHALL drive no dec_stb in that cycle or afterwards.
REQ-021 SHALL latch cfg_ratio into an active-ratio register on cfg_load in any state.
REQ-022 SHALL, when cfg_load occurs in SETTLE or RUN, go to SETTLE and clear the phase, settle and capture-pending state.
REQ-023 SHALL give en=0 priority over a simultaneous cfg_load; the ratio is still latched in that case.
REQ-024 SHALL run the phase counter 0..R-1 in SETTLE and RUN, wrap to 0 after R-1, and hold at 0 in IDLE.
REQ-025 SHALL assert dec_stb exactly in cycles where phase==R-1, giving one strobe per R clocks with the first strobe R cycles after entering SETTLE.
REQ-026 SHALL treat the filter as having a one-cycle latency: cic_out is sampled in the cycle after a RUN-state dec_stb.
REQ-027 SHALL not capture dec_stb events that occur in SETTLE.
REQ-028 SHALL, on capture, load out_data and set out_valid=1.
REQ-029 SHALL clear out_valid on an out_valid && out_ready cycle with no simultaneous capture.
REQ-030 SHALL, on a capture in the same cycle as out_ready && out_valid, load the new data and keep out_valid=1 with no overrun.
REQ-031 SHALL, on a capture while out_valid && !out_ready, overwrite out_data and set overrun.
REQ-032 SHALL clear overrun on clr_ovr, except that a set event in the same cycle wins.
REQ-033 SHALL leave out_data and out_valid unchanged on entry to IDLE, so that the last sample remains consumable.

Reset
REQ-034 SHALL, on rst: state=IDLE, active ratio=2, phase=0, settle count=0, dec_stb=0, out_data=0, out_valid=0, overrun=0, capture-pending=0.
REQ-035 SHALL take reset effect immediately (asynchronously) and SHALL sample en first at the first clock edge after rst deasserts.
REQ-036 SHALL, on rst mid-operation, discard any pending capture.

Structure
REQ-037 SHALL place the state encoding type, state codes and default parameter constants in package cic_ctrl_pkg.
REQ-038 SHALL contain one sub-module, decim_phase_counter, which holds the ratio register, phase counter and strobe generation, with clear and enable inputs.
REQ-039 SHALL register all outputs; dec_stb SHALL be derived combinationally from a registered phase.

Verification
REQ-040 SHALL cover: rst, R=4 loaded, en=1 -> dec_stb at cycles 4, 8, 12, ...; state==RUN after the 3rd strobe; first capture one cycle after the 4th strobe.
REQ-041 SHALL cover: RUN, out_ready held 0, two captures -> out_data = second cic_out value, overrun=1; clr_ovr -> overrun=0.
REQ-042 SHALL cover: capture coinciding with an out_ready handshake -> out_valid stays 1, overrun stays 0.
REQ-043 SHALL cover: cfg_load R=8 mid-RUN -> state=SETTLE, the next strobe 8 cycles later, and 3 discarded strobes before captures resume.
REQ-044 SHALL cover: cfg_ratio=0 or 1 -> strobe period 2; en dropped mid-RUN -> IDLE, no further dec_stb, out_valid retained.
REQ-045 SHALL cover: rst asserted between an out_valid capture and out_ready -> out_valid=0 immediately, with no capture after release until the SETTLE sequence completes.
